// File: rtl/seg7_pkg.sv
// Seven-segment pattern table and helpers shared by the display encoder and decoder.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } seg7_state_t;

  // Active-low {g,f,e,d,c,b,a}: a lit segment is a 0 bit.
  localparam seg7_t SEG_0     = 7'b1000000;
  localparam seg7_t SEG_1     = 7'b1111001;
  localparam seg7_t SEG_2     = 7'b0100100;
  localparam seg7_t SEG_3     = 7'b0110000;
  localparam seg7_t SEG_4     = 7'b0011001;
  localparam seg7_t SEG_5     = 7'b0010010;
  localparam seg7_t SEG_6     = 7'b0000010;
  localparam seg7_t SEG_7     = 7'b1111000;
  localparam seg7_t SEG_8     = 7'b0000000;
  localparam seg7_t SEG_9     = 7'b0011000;
  localparam seg7_t SEG_BLANK = 7'b1111111;

  // Bits needed to hold any value up to 10^digits - 1.
  function automatic int unsigned seg7_width(input int unsigned digits);
    longint unsigned p;
    int unsigned     w;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) p = p * 10;
    w = 0;
    while ((64'd1 << w) < p) w++;
    return w;
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one active-low seven-segment pattern to BCD.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  seg7_t      seg_i,
  output logic       legal_o,
  output logic       blank_o,
  output logic [3:0] bcd_o
);

  always_comb begin
    legal_o = 1'b1;
    blank_o = 1'b0;
    bcd_o   = 4'd0;
    case (seg_i)
      SEG_0:     bcd_o = 4'd0;
      SEG_1:     bcd_o = 4'd1;
      SEG_2:     bcd_o = 4'd2;
      SEG_3:     bcd_o = 4'd3;
      SEG_4:     bcd_o = 4'd4;
      SEG_5:     bcd_o = 4'd5;
      SEG_6:     bcd_o = 4'd6;
      SEG_7:     bcd_o = 4'd7;
      SEG_8:     bcd_o = 4'd8;
      SEG_9:     bcd_o = 4'd9;
      SEG_BLANK: blank_o = 1'b1;
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_to_num.sv
// Converts a word of active-low seven-segment digits back to binary,
// one digit per clock, most-significant digit first.
module seg7_to_num
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned OUT_W      = 32,
  localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7*NUM_DIGITS-1:0] segs,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        num,
  output logic                    err,
  output logic [IDX_W-1:0]        err_digit
);

  if (OUT_W < seg7_width(NUM_DIGITS)) begin : g_width_check
    $error("seg7_to_num: OUT_W too narrow for NUM_DIGITS");
  end

  seg7_state_t             state_q;
  logic [7*NUM_DIGITS-1:0] segs_q;
  logic [OUT_W-1:0]        acc_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    err_pend_q;
  logic [IDX_W-1:0]        err_idx_q;
  logic                    nonblank_q;
  logic                    out_valid_q;
  logic [OUT_W-1:0]        num_q;
  logic                    err_q;
  logic [IDX_W-1:0]        err_digit_q;

  seg7_t            digit_w [NUM_DIGITS];
  seg7_t            cur_seg;
  logic             dec_legal;
  logic             dec_blank;
  logic [3:0]       dec_bcd;
  logic             digit_bad;
  logic             err_d;
  logic [IDX_W-1:0] err_idx_d;
  logic [OUT_W-1:0] acc_d;

  always_comb begin
    for (int unsigned k = 0; k < NUM_DIGITS; k++) digit_w[k] = segs_q[7*k +: 7];
  end

  assign cur_seg = digit_w[idx_q];

  seg7_digit_decode u_dec (
    .seg_i   (cur_seg),
    .legal_o (dec_legal),
    .blank_o (dec_blank),
    .bcd_o   (dec_bcd)
  );

  // A blank is only a leading-zero suppressor; once a real digit was seen it is an error.
  assign digit_bad = !dec_legal || (dec_blank && nonblank_q);
  assign err_d     = err_pend_q || digit_bad;
  assign err_idx_d = err_pend_q ? err_idx_q : idx_q;
  assign acc_d     = (acc_q << 3) + (acc_q << 1) + {{(OUT_W-4){1'b0}}, dec_bcd};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      segs_q      <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      err_pend_q  <= 1'b0;
      err_idx_q   <= '0;
      nonblank_q  <= 1'b0;
      out_valid_q <= 1'b0;
      num_q       <= '0;
      err_q       <= 1'b0;
      err_digit_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            segs_q     <= segs;
            acc_q      <= '0;
            idx_q      <= IDX_W'(NUM_DIGITS - 1);
            err_pend_q <= 1'b0;
            err_idx_q  <= '0;
            nonblank_q <= 1'b0;
            state_q    <= ACC;
          end
        end
        ACC: begin
          acc_q      <= acc_d;
          nonblank_q <= nonblank_q | !dec_blank;
          if (digit_bad && !err_pend_q) begin
            err_pend_q <= 1'b1;
            err_idx_q  <= idx_q;
          end
          if (idx_q == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            num_q       <= err_d ? '0 : acc_d;
            err_q       <= err_d;
            err_digit_q <= err_d ? err_idx_d : '0;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign num       = num_q;
  assign err       = err_q;
  assign err_digit = err_digit_q;

endmodule

// File: tb/tb_seg7_to_num.sv
// Directed and randomized checks of seg7_to_num against a digit-table reference model.
module tb_seg7_to_num;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] segs;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] num;
  logic        err;
  logic [1:0]  err_digit;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_to_num #(.NUM_DIGITS(3), .OUT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .segs      (segs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .num       (num),
    .err       (err),
    .err_digit (err_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100,
                         P3 = 7'b0110000, P4 = 7'b0011001, P5 = 7'b0010010,
                         P6 = 7'b0000010, P7 = 7'b1111000, P8 = 7'b0000000,
                         P9 = 7'b0011000, PB = 7'b1111111;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return P0;  1: return P1;  2: return P2;  3: return P3;
      4: return P4;  5: return P5;  6: return P6;  7: return P7;
      8: return P8;  9: return P9;  default: return PB;
    endcase
  endfunction

  // 0..9 digit value, 10 blank, -1 illegal
  function automatic int lookup(input logic [6:0] p);
    for (int d = 0; d <= 10; d++) if (pat(d) == p) return d;
    return -1;
  endfunction

  task automatic model(input logic [20:0] w, output longint n, output logic e,
                       output logic [1:0] ed);
    bit seen;
    int d;
    logic [6:0] p;
    n = 0; e = 1'b0; ed = 2'd0; seen = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      p = w[7*k +: 7];
      d = lookup(p);
      if (d < 0 || (d == 10 && seen)) begin
        if (!e) begin e = 1'b1; ed = k[1:0]; end
      end
      if (d != 10) seen = 1'b1;
      n = n * 10 + ((d >= 0 && d <= 9) ? d : 0);
    end
    if (e) n = 0;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Must be called right after a falling edge.
  task automatic send(input logic [20:0] w, input int hold, input logic pre,
                      input logic [20:0] nxt);
    int t;
    longint en;
    logic ee;
    logic [1:0] eed;
    model(w, en, ee, eed);
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    check("in_ready_wait", longint'(in_ready), 1);
    segs = w; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    segs = 21'($urandom);
    check("in_ready_busy", longint'(in_ready), 0);
    t = 0;
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    check("latency", t, 3);
    check("num", longint'(num), en);
    check("err", longint'(err), longint'(ee));
    check("err_digit", longint'(err_digit), longint'(eed));
    for (int i = 0; i < hold; i++) begin
      if (pre) begin in_valid = 1'b1; segs = nxt; end
      @(negedge clk);
      check("hold_valid", longint'(out_valid), 1);
      check("hold_num", longint'(num), en);
      check("hold_err", longint'(err), longint'(ee));
      check("hold_in_ready", longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_valid", longint'(out_valid), 0);
    check("drain_in_ready", longint'(in_ready), 1);
  endtask

  initial begin
    logic [20:0] w;
    int r;
    logic [6:0] g;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; segs = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_num", longint'(num), 0);
    check("rst_err", longint'(err), 0);
    check("rst_err_digit", longint'(err_digit), 0);
    check("rst_in_ready", longint'(in_ready), 1);

    send({P1, P2, P3}, 0, 1'b0, '0);
    check("d123", longint'(num), 123);
    send({PB, PB, P7}, 0, 1'b0, '0);
    send({PB, PB, PB}, 0, 1'b0, '0);
    send({P9, P9, P9}, 0, 1'b0, '0);
    check("d999", longint'(num), 999);
    send({P9, PB, P0}, 0, 1'b0, '0);
    send({7'b0101010, P5, 7'b1111110}, 1, 1'b0, '0);
    send({P4, P5, P6}, 5, 1'b1, {P7, P8, P9});
    send({P7, P8, P9}, 0, 1'b0, '0);
    check("d789", longint'(num), 789);

    segs = {P3, P2, P1}; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", longint'(in_ready), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_valid", longint'(out_valid), 0);
    end
    send({P0, P4, P5}, 0, 1'b0, '0);
    check("d045", longint'(num), 45);

    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 3; k++) begin
        r = $urandom_range(0, 13);
        if (r <= 9) g = pat(r);
        else if (r <= 12) g = PB;
        else begin
          g = 7'($urandom);
          while (lookup(g) >= 0) g = 7'($urandom);
        end
        w[7*k +: 7] = g;
      end
      send(w, $urandom_range(0, 2), 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
